// File: rtl/board_test_led_sequencer.sv
// board_test_led_sequencer: debounced pushbutton stepping a 3-LED self-test pattern sequencer
// Ports: clk; rst_n (async assert, active-low); button_press (raw level, async to clk);
//        led_display[2:0] (registered pattern); mode[2:0] (current mode); press_pulse (1-cycle strobe per press)
// Optional: define BOARD_TEST_AUTO_ADVANCE_EN to auto-advance after 16 idle ticks in any mode except OFF.
module board_test_led_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_press,
  output logic [2:0] led_display,
  output logic [2:0] mode,
  output logic       press_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(BLINK_DIV);
  typedef enum logic [2:0] {OFF = 3'd0, ALL_ON = 3'd1, BLINK = 3'd2, WALK = 3'd3, COUNT = 3'd4} mode_t;
  mode_t state, state_next;
  logic s1, s2, debounced, accept, rise, tick, advance, changed;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] presc;
  logic [2:0] step, led_next;
  assign mode = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button_press;
      s2 <= s1;
    end
  // Accept the new level once it has differed for DEBOUNCE_CYCLES consecutive edges.
  assign accept = s2 != debounced && deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign rise = accept && s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      debounced <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 == debounced) begin
      deb_cnt <= '0;
    end else if (accept) begin
      debounced <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  assign tick = presc == PW'(BLINK_DIV - 1);
`ifdef BOARD_TEST_AUTO_ADVANCE_EN
  logic [3:0] idle_cnt;
  logic auto_adv;
  assign auto_adv = tick && state != OFF && idle_cnt == 4'd15;
  assign advance = rise || auto_adv;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (changed || rise) ? 4'd0 : (tick && state != OFF) ? idle_cnt + 4'd1 : idle_cnt;
`else
  assign advance = rise;
`endif
  assign changed = state_next != state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= OFF;
    else state <= state_next;
  always_comb
    state_next = state > COUNT ? OFF : !advance ? state : state == COUNT ? OFF : mode_t'(state + 3'd1);
  // A mode change restarts the pattern timing and wins over a coincident tick.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc <= '0;
      step <= '0;
      press_pulse <= 1'b0;
      led_display <= 3'b000;
    end else begin
      presc <= (changed || tick) ? '0 : presc + 1'b1;
      step <= changed ? 3'd0 : !tick ? step : (state == WALK && step == 3'd2) ? 3'd0 : step + 3'd1;
      press_pulse <= rise;
      led_display <= led_next;
    end
  // WALK wraps its step at 3 so the rotation stays aligned; COUNT uses the full 3-bit step.
  always_comb begin
    led_next = 3'b000;
    case (state)
      ALL_ON: led_next = 3'b111;
      BLINK:  led_next = step[0] ? 3'b000 : 3'b111;
      WALK:   led_next = step == 3'd1 ? 3'b010 : step == 3'd2 ? 3'b100 : 3'b001;
      COUNT:  led_next = step;
      default: led_next = 3'b000;
    endcase
  end
endmodule

// File: tb/tb_board_test_led_sequencer.sv
// tb_board_test_led_sequencer: randomized and directed checks of the LED sequencer against a behavioural model
module tb_board_test_led_sequencer;
  localparam int D = 4;
  localparam int B = 2;
`ifdef BOARD_TEST_AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, button_press = 1'b0;
  logic [2:0] led_display, mode;
  logic press_pulse;
  int checks = 0, errors = 0;

  board_test_led_sequencer #(.DEBOUNCE_CYCLES(D), .BLINK_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .button_press(button_press),
    .led_display(led_display), .mode(mode), .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pat(int md, int since);
    int s;
    s = since / B;
    case (md)
      1: return 3'b111;
      2: return (s % 2) ? 3'b000 : 3'b111;
      3: return 3'(1 << (s % 3));
      4: return 3'(s % 8);
      default: return 3'b000;
    endcase
  endfunction

  int m_mode = 0, m_since = 0, m_run = 0;
  bit m_deb = 0, m_p1 = 0, m_p2 = 0, m_pp = 0, m_lvl, m_press;
  logic [2:0] m_led = 3'b000;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_since = 0; m_run = 0; m_deb = 0; m_p1 = 0; m_p2 = 0; m_pp = 0; m_led = 3'b000;
    end else begin
      m_lvl = m_p2;
      m_p2 = m_p1;
      m_p1 = button_press;
      m_press = 0;
      if (m_lvl != m_deb) begin
        m_run++;
        if (m_run == D) begin
          m_deb = m_lvl;
          m_run = 0;
          m_press = m_lvl;
        end
      end else m_run = 0;
      m_led = pat(m_mode, m_since);
      m_pp = m_press;
      if (m_press || (AUTO && m_mode != 0 && m_since == 16 * B - 1)) begin
        m_mode = (m_mode + 1) % 5;
        m_since = 0;
      end else m_since++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    button_press = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press();
    bit ok = 0;
    repeat (D + 4) @(negedge clk);
    button_press = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (press_pulse === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL press_wait: press_pulse stayed 0, required 1 within 40 cycles"); end
    @(negedge clk);
    button_press = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    button_press = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({mode, led_display, press_pulse} !== 7'b0) begin
        errors++; $display("FAIL reset_hold: mode=%0d led=%b pp=%b required 0 000 0", mode, led_display, press_pulse);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= D + 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (press_pulse !== (k == D + 1)) begin
        errors++; $display("FAIL reset_press pp edge N+%0d: got %b required %b", k, press_pulse, k == D + 1);
      end
      checks++;
      if (mode !== (k >= D + 1 ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL reset_press mode edge N+%0d: got %0d", k, mode);
      end
    end
    checks++;
    if (led_display !== 3'b111) begin errors++; $display("FAIL reset_press led: got %b required 111", led_display); end
    button_press = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    repeat (3) @(negedge clk);
    button_press = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (press_pulse !== (k == D + 1) || mode !== (k >= D + 1 ? 3'd1 : 3'd0) ||
          led_display !== (k >= D + 2 ? 3'b111 : 3'b000)) begin
        errors++; $display("FAIL clean_press edge N+%0d: pp=%b mode=%0d led=%b", k, press_pulse, mode, led_display);
      end
    end
    @(negedge clk);
    button_press = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      checks++;
      if (press_pulse !== 1'b0 || mode !== 3'd1 || led_display !== 3'b111) begin
        errors++; $display("FAIL release: pp=%b mode=%0d led=%b required 0 1 111", press_pulse, mode, led_display);
      end
    end
  endtask

  task automatic test_glitch();
    for (int len = 1; len < D; len++) begin
      do_reset();
      @(negedge clk);
      button_press = 1'b1;
      repeat (len) @(negedge clk);
      button_press = 1'b0;
      repeat (12) begin
        @(posedge clk); #1;
        checks++;
        if (press_pulse !== 1'b0 || mode !== 3'd0) begin
          errors++; $display("FAIL glitch len=%0d: pp=%b mode=%0d required 0 0", len, press_pulse, mode);
        end
      end
    end
  endtask

  task automatic test_patterns();
    logic [2:0] exp;
    do_reset();
    repeat (3) press();
    checks++;
    if (mode !== 3'd3) begin errors++; $display("FAIL walk_mode: got %0d required 3", mode); end
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      exp = 3'(1 << ((j / B) % 3));
      checks++;
      if (led_display !== exp) begin errors++; $display("FAIL walk j=%0d: led=%b required %b", j, led_display, exp); end
    end
    press();
    for (int j = 0; j < 18; j++) begin
      @(posedge clk); #1;
      exp = 3'((j / B) % 8);
      checks++;
      if (mode !== 3'd4 || led_display !== exp) begin
        errors++; $display("FAIL count j=%0d: mode=%0d led=%b required 4 %b", j, mode, led_display, exp);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press();
      checks++;
      if (mode !== 3'((i + 1) % 5)) begin errors++; $display("FAIL wrap press %0d: mode=%0d required %0d", i, mode, (i + 1) % 5); end
    end
    @(posedge clk); #1;
    checks++;
    if (led_display !== 3'b000) begin errors++; $display("FAIL wrap_off led: got %b required 000", led_display); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (2) press();
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (mode !== 3'd2) begin errors++; $display("FAIL mid_reset pre: mode=%0d required 2", mode); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mode, led_display, press_pulse} !== 7'b0) begin
      errors++; $display("FAIL mid_reset: mode=%0d led=%b pp=%b required 0 000 0", mode, led_display, press_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [2:0] exp;
    do_reset();
    press();
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      exp = (AUTO && j >= 16 * B) ? 3'd2 : 3'd1;
      checks++;
      if (press_pulse !== 1'b0 || mode !== exp) begin
        errors++; $display("FAIL idle j=%0d: pp=%b mode=%0d required 0 %0d", j, press_pulse, mode, exp);
      end
    end
  endtask

  task automatic test_random();
    int left = 0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (left == 0) begin
        button_press = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 3 * D);
      end
      left--;
      @(posedge clk); #1;
      checks++;
      if (mode !== 3'(m_mode) || led_display !== m_led || press_pulse !== m_pp) begin
        errors++;
        $display("FAIL random cyc=%0d: mode=%0d led=%b pp=%b required %0d %b %b", c, mode, led_display, press_pulse, m_mode, m_led, m_pp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_patterns();
    test_wrap();
    test_mid_reset();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
